// File: rtl/small_fifo_ram.sv
// Storage array for fwft_small_fifo: synchronous write port, address-indexed
// (combinational) read port so the owner can pre-fetch the next head word.
module small_fifo_ram #(
    parameter int WIDTH     = 72,
    parameter int ADDR_BITS = 3
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [WIDTH-1:0]     rd_data
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fwft_small_fifo.sv
// Small synchronous first-word-fall-through FIFO. The head word sits in a
// register (dout) that is reloaded at each edge from the post-edge head.
module fwft_small_fifo #(
    parameter int WIDTH               = 72,
    parameter int MAX_DEPTH_BITS      = 3,
    parameter int PROG_FULL_THRESHOLD = 2 ** MAX_DEPTH_BITS - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             nearly_full,
    output logic             prog_full,
    output logic             empty
);

    localparam int DEPTH = 2 ** MAX_DEPTH_BITS;
    localparam int CW    = MAX_DEPTH_BITS + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] NF_CNT   = CW'(DEPTH - 1);
    localparam logic [CW-1:0] PF_CNT   = CW'(PROG_FULL_THRESHOLD);

    logic [MAX_DEPTH_BITS-1:0] wr_ptr;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr_next;
    logic [CW-1:0]             count;
    logic [CW-1:0]             count_next;
    logic [WIDTH-1:0]          ram_rd_data;
    logic [WIDTH-1:0]          head_next;
    logic                      do_wr;
    logic                      do_rd;

    // Handshake: a push (wr_en) is accepted when !full, or when full with a
    // simultaneous pop; rd_en acknowledges dout and is honoured only while !empty.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || rd_en);

    always_comb begin
        rd_ptr_next = rd_ptr;
        count_next  = count;
        head_next   = ram_rd_data;
        if (do_rd) begin
            rd_ptr_next = rd_ptr + 1'b1;
        end
        if (do_wr && !do_rd) begin
            count_next = count + 1'b1;
        end else if (do_rd && !do_wr) begin
            count_next = count - 1'b1;
        end
        // The new head is the word being written this edge when the FIFO is
        // (or becomes) otherwise empty; the array has not captured it yet.
        if (do_wr && (wr_ptr == rd_ptr_next)) begin
            head_next = din;
        end
    end

    small_fifo_ram #(
        .WIDTH    (WIDTH),
        .ADDR_BITS(MAX_DEPTH_BITS)
    ) u_ram (
        .clk    (clk),
        .wr_en  (do_wr && !reset),
        .wr_addr(wr_ptr),
        .wr_data(din),
        .rd_addr(rd_ptr_next),
        .rd_data(ram_rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            dout        <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            nearly_full <= 1'b0;
            prog_full   <= 1'b0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr      <= rd_ptr_next;
            count       <= count_next;
            if (count_next != '0) begin
                dout <= head_next;
            end
            empty       <= (count_next == '0);
            full        <= (count_next == FULL_CNT);
            nearly_full <= (count_next >= NF_CNT);
            prog_full   <= (count_next >= PF_CNT);
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (wr_en && full && !rd_en) begin
                $warning("fwft_small_fifo overflow: write dropped at time %0t in %m", $time);
            end
            if (rd_en && empty) begin
                $warning("fwft_small_fifo underflow: read ignored at time %0t in %m", $time);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fwft_small_fifo.sv
// Self-checking bench for fwft_small_fifo: a queue model of the FIFO contents
// supplies the expected head word and flags after every clock edge.
module tb_fwft_small_fifo;

    localparam int W = 20;

    logic         clk;
    logic         reset;
    logic [W-1:0] din;
    logic         wr_en;
    logic         rd_en;
    logic [W-1:0] dout;
    logic         full;
    logic         nearly_full;
    logic         prog_full;
    logic         empty;

    logic [W-1:0] exp_q[$];
    int           n_checks;
    int           n_errors;

    fwft_small_fifo #(
        .WIDTH         (W),
        .MAX_DEPTH_BITS(3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .dout       (dout),
        .full       (full),
        .nearly_full(nearly_full),
        .prog_full  (prog_full),
        .empty      (empty)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_state(input string tag);
        int n;
        n = exp_q.size();
        check({tag, ".empty"}, 32'(empty), 32'(n == 0));
        check({tag, ".full"}, 32'(full), 32'(n == 8));
        check({tag, ".nearly_full"}, 32'(nearly_full), 32'(n >= 7));
        check({tag, ".prog_full"}, 32'(prog_full), 32'(n >= 7));
        if (n > 0) begin
            check({tag, ".dout"}, 32'(dout), 32'(exp_q[0]));
        end
    endtask

    // driver: called at a falling edge, returns at the next falling edge
    task automatic cycle(input logic w, input logic [W-1:0] d, input logic r, input string tag);
        bit m_empty;
        bit m_full;
        m_empty = (exp_q.size() == 0);
        m_full  = (exp_q.size() == 8);
        wr_en = w;
        din   = d;
        rd_en = r;
        if (r && !m_empty) begin
            check({tag, ".pop"}, 32'(dout), 32'(exp_q.pop_front()));
        end
        if (w && (!m_full || r)) begin
            exp_q.push_back(d);
        end
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        check_state(tag);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        wr_en = 1'b1;
        rd_en = 1'b1;
        din   = W'($urandom);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        exp_q.delete();
        check_state(tag);
        check({tag, ".dout_zero"}, 32'(dout), 32'h0);
    endtask

    task automatic drain(input string tag);
        int n;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, '0, 1'b1, tag);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = '0;
        exp_q.delete();
        @(negedge clk);
        do_reset("reset");

        // underflow is ignored
        cycle(1'b0, '0, 1'b1, "underflow");

        // fall-through
        cycle(1'b1, W'('h12345), 1'b0, "fwft_write");
        cycle(1'b0, '0, 1'b1, "fwft_read");

        // fill, flags and overflow drop
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, W'(i), 1'b0, "fill");
        end
        cycle(1'b1, W'('h9), 1'b0, "overflow");
        drain("drain_fill");

        // simultaneous push/pop with 3 queued
        cycle(1'b1, W'('hA), 1'b0, "sim_pre");
        cycle(1'b1, W'('hB), 1'b0, "sim_pre");
        cycle(1'b1, W'('hC), 1'b0, "sim_pre");
        cycle(1'b1, W'('hD), 1'b1, "sim_rw");
        cycle(1'b1, W'('hE), 1'b1, "sim_rw");
        drain("sim_drain");

        // full with simultaneous read/write
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, W'(32'h100 + i), 1'b0, "full_fill");
        end
        cycle(1'b1, W'('hE), 1'b1, "full_rw");
        drain("full_drain");

        // continuous streaming across the pointer wrap
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, W'($urandom), (i > 0), "wrap");
        end
        drain("wrap_drain");

        // random traffic
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom_range(0, 99) < 55), W'($urandom), ($urandom_range(0, 99) < 45), "random");
        end
        drain("random_drain");

        // reset mid-operation with 5 words queued
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, W'(32'h200 + i), 1'b0, "pre_reset");
        end
        do_reset("mid_reset");
        cycle(1'b1, W'('h55), 1'b0, "post_reset");
        check("post_reset.dout_alone", 32'(dout), 32'h55);
        cycle(1'b0, '0, 1'b1, "post_reset_read");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
